// File: rtl/bus_pkg.sv
// bus_pkg: shared state, mode and width definitions for the serial system bus
package bus_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_SLAVE_MEM_ADDR_WIDTH = 12;
  localparam logic READ = 1'b0;
  localparam logic WRITE = 1'b1;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    MEMW  = 3'd3,
    MEMR  = 3'd4,
    RDATA = 3'd5
  } state_e;
endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: indexed serial-in/parallel-out and parallel-in/serial-out register with bit counter
module bit_serializer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  input  logic         wr,
  input  logic         load,
  input  logic         din,
  input  logic [W-1:0] pdin,
  output logic [W-1:0] pnext,
  output logic         sout,
  output logic [7:0]   cnt
);
  localparam int IW = $clog2(W);
  logic [W-1:0] sh_q, sh_d;
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    sh_d = load ? pdin : sh_q;
    if (wr) sh_d[cnt_q[IW-1:0]] = din;
    cnt_d = (clr ? 8'd0 : cnt_q) + {7'd0, adv};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q <= sh_d;
      cnt_q <= cnt_d;
    end
  end
  assign pnext = sh_d;
  assign sout = sh_q[cnt_q[IW-1:0]];
  assign cnt = cnt_q;
endmodule

// File: rtl/slave_port.sv
// slave_port: serial bus slave endpoint; define SLAVE_SPLIT_EN to enable read split requests
module slave_port
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SLAVE_MEM_ADDR_WIDTH = DEF_SLAVE_MEM_ADDR_WIDTH,
  parameter int SPLIT_THRESHOLD = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            swdata,
  input  logic                            smode,
  input  logic                            mvalid,
  output logic                            srdata,
  output logic                            svalid,
  output logic                            sready,
  output logic                            ssplit,
  output logic [SLAVE_MEM_ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0]           smemwdata,
  output logic                            smemwen,
  output logic                            smemren,
  input  logic [DATA_WIDTH-1:0]           smemrdata,
  input  logic                            smemrvalid
);
`ifdef SLAVE_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  localparam int AW = SLAVE_MEM_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = AW > DW ? AW : DW;
  state_e state_q, state_d;
  logic mode_q, mode_d;
  logic srdata_q, srdata_d, svalid_q, svalid_d, ssplit_q, ssplit_d;
  logic smemwen_q, smemwen_d, smemren_q, smemren_d;
  logic [AW-1:0] smemaddr_q, smemaddr_d;
  logic [DW-1:0] smemwdata_q, smemwdata_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic clr, adv, wr, load, sout;
  logic [SW-1:0] pnext;
  logic [7:0] cnt;
  bit_serializer #(.W(SW)) u_ser (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .adv(adv),
    .wr(wr),
    .load(load),
    .din(swdata),
    .pdin(SW'(smemrdata)),
    .pnext(pnext),
    .sout(sout),
    .cnt(cnt)
  );
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    srdata_d = 1'b0;
    svalid_d = 1'b0;
    ssplit_d = 1'b0;
    smemwen_d = 1'b0;
    smemren_d = 1'b0;
    smemaddr_d = smemaddr_q;
    smemwdata_d = smemwdata_q;
    wcnt_d = 8'd0;
    clr = 1'b0;
    adv = 1'b0;
    wr = 1'b0;
    load = 1'b0;
    case (state_q)
      IDLE: if (mvalid) begin
        wr = 1'b1;
        adv = 1'b1;
        clr = 1'b1;
        mode_d = smode;
        state_d = ADDR;
      end
      ADDR: if (mvalid) begin
        wr = 1'b1;
        adv = cnt != 8'(AW-1);
        if (cnt == 8'(AW-1)) begin
          clr = 1'b1;
          smemaddr_d = pnext[AW-1:0];
          state_d = mode_q == WRITE ? WDATA : MEMR;
          smemren_d = mode_q == READ;
        end
      end
      WDATA: if (mvalid) begin
        wr = 1'b1;
        adv = cnt != 8'(DW-1);
        if (cnt == 8'(DW-1)) begin
          clr = 1'b1;
          smemwdata_d = pnext[DW-1:0];
          state_d = MEMW;
          smemwen_d = 1'b1;
        end
      end
      MEMW: state_d = IDLE;
      MEMR: if (smemrvalid) begin
        load = 1'b1;
        clr = 1'b1;
        adv = !ssplit_q;
        svalid_d = !ssplit_q;
        srdata_d = !ssplit_q && smemrdata[0];
        state_d = RDATA;
      end else begin
        wcnt_d = wcnt_q + {7'd0, !ssplit_q};
        ssplit_d = SPLIT_EN && (ssplit_q || (wcnt_q + 8'd1 == 8'(SPLIT_THRESHOLD)));
      end
      RDATA: if (cnt == 8'(DW)) begin
        clr = 1'b1;
        state_d = IDLE;
      end else begin
        adv = 1'b1;
        svalid_d = 1'b1;
        srdata_d = sout;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= READ;
      srdata_q <= 1'b0;
      svalid_q <= 1'b0;
      ssplit_q <= 1'b0;
      smemwen_q <= 1'b0;
      smemren_q <= 1'b0;
      smemaddr_q <= '0;
      smemwdata_q <= '0;
      wcnt_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      srdata_q <= srdata_d;
      svalid_q <= svalid_d;
      ssplit_q <= ssplit_d;
      smemwen_q <= smemwen_d;
      smemren_q <= smemren_d;
      smemaddr_q <= smemaddr_d;
      smemwdata_q <= smemwdata_d;
      wcnt_q <= wcnt_d;
    end
  end
  assign sready = state_q == IDLE;
  assign srdata = srdata_q;
  assign svalid = svalid_q;
  assign ssplit = ssplit_q;
  assign smemwen = smemwen_q;
  assign smemren = smemren_q;
  assign smemaddr = smemaddr_q;
  assign smemwdata = smemwdata_q;
endmodule

// File: doc/slave_port.md
# slave_port

Slave-side endpoint of the serial system bus. It deserialises the memory address and write data that the master port shifts out LSB-first, then performs a single-cycle write or a variable-latency read on the attached slave memory/device. For reads, it serialises the data back to the master LSB-first. It sits between the address-decoder/bus mux and one slave device, and is the responder counterpart to the master port.

## Interface
Parameters:
- DATA_WIDTH, 8: data word width in bits.
- SLAVE_MEM_ADDR_WIDTH, 12: width of the slave-internal memory address.
- SPLIT_THRESHOLD, 4: read-wait cycles before a split is raised (used only with SLAVE_SPLIT_EN).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- swdata  in  1  serial write bit (address/data) from the bus.
- smode  in  1  transaction mode: 0 = read, 1 = write. Sampled with the first address bit.
- mvalid  in  1  swdata valid.
- srdata  out  1  serial read bit to the bus.
- svalid  out  1  srdata valid.
- sready  out  1  high in IDLE; the decoder only acks this slave when sready = 1.
- ssplit  out  1  split request to the arbiter.
- smemaddr  out  SLAVE_MEM_ADDR_WIDTH  memory address.
- smemwdata  out  DATA_WIDTH  memory write data.
- smemwen  out  1  one-cycle write strobe.
- smemren  out  1  one-cycle read strobe.
- smemrdata  in  DATA_WIDTH  memory read data.
- smemrvalid  in  1  smemrdata valid; may arrive 1+ cycles after smemren.

## Operation
- States:
  - IDLE: on mvalid, capture bit 0 of the address and smode, then go to ADDR.
  - ADDR: address bit[counter] is captured on each cycle with mvalid = 1. After bit SLAVE_MEM_ADDR_WIDTH-1, go to WDATA if mode = 1, otherwise go to MEMR.
  - WDATA: wdata bit[counter] is captured on each cycle with mvalid = 1. After bit DATA_WIDTH-1, go to MEMW.
  - MEMW: smemwen = 1 for exactly one cycle, then go to IDLE.
  - MEMR: smemren = 1 in the first cycle only. Wait for smemrvalid, latch smemrdata, then go to RDATA.
  - RDATA: drive srdata = rdata[counter] with svalid = 1 for DATA_WIDTH consecutive cycles, then go to IDLE.
- Gaps (mvalid = 0) in ADDR/WDATA hold the state and the counter. There is no timeout.
- The counter is 8 bits. It clears on every state change and on reaching the field width, so it never wraps.
- swdata/mvalid are ignored in MEMR, RDATA and MEMW.
- smemaddr and smemwdata hold their last-captured values between transactions.
- smemrvalid outside MEMR is ignored.

## Timing
- Reset values: srdata = 0, svalid = 0, ssplit = 0, smemwen = 0, smemren = 0, smemaddr = 0, smemwdata = 0, sready = 1, state = IDLE, counter = 0.
- rst mid-transaction discards the partial transaction and returns to IDLE on the next edge. No memory strobe is issued.
- All outputs are registered except sready, which is decoded from state.
- Write latency, with a gap-free stream: smemwen is asserted one cycle after the last data bit is sampled.
- Read: smemren is asserted in the cycle after the last address bit. The first svalid is in the cycle after smemrvalid is sampled.
- Minimum read turnaround, from last address bit to first data bit: 3 cycles with 1-cycle memory latency.
- smemrvalid in the same cycle as smemren is legal. Data is latched and RDATA follows on the next cycle.

## Configuration
- SLAVE_SPLIT_EN defined:
  - In MEMR, a wait counter runs. When it reaches SPLIT_THRESHOLD without smemrvalid, ssplit is asserted.
  - ssplit holds until smemrvalid is sampled, then drops in the same edge that enters RDATA.
  - svalid streaming starts one cycle later, so the master sees msplit low before data.
  - smemrvalid arriving exactly at the threshold does not raise ssplit.
- SLAVE_SPLIT_EN undefined: ssplit is tied to 0, and MEMR waits indefinitely.

## Structure
- Shared package bus_pkg holds:
  - state encoding localparams (IDLE, ADDR, WDATA, MEMW, MEMR, RDATA);
  - the mode encodings READ = 0 and WRITE = 1;
  - the default DATA_WIDTH and SLAVE_MEM_ADDR_WIDTH.
- The package is shared with the master port and the decoder.
- Natural sub-module: bit_serializer. It is a parameterised serial-in/parallel-out plus parallel-in/serial-out shift register with a bit counter. It is instantiated once for the address/data capture and reused for read serialisation.
- The FSM and split timer stay in slave_port.

## Test plan
- Write: smode = 1, address 0x5A3 LSB-first then data 0xC6 → one-cycle smemwen with smemaddr = 0x5A3 and smemwdata = 0xC6; sready returns high next cycle.
- Read with 1-cycle memory: address 0x0FF, smode = 0, smemrdata = 0x3C → svalid high for 8 cycles with srdata = 0,0,1,1,1,1,0,0.
- Gapped stream: mvalid low for 3 cycles after address bit 5 → address is still captured exactly; no extra bits are taken.
- Reset mid-WDATA: rst after 4 data bits → no smemwen; all outputs are at reset values; the next full write 0x001/0xFF succeeds.
- SLAVE_SPLIT_EN with SPLIT_THRESHOLD = 4 and memory latency 10 → ssplit rises 4 cycles after smemren and falls on data capture; 0x81 is then streamed correctly.
- Memory latency 2 with SLAVE_SPLIT_EN → ssplit never asserts.
